bundle_vec_unpack: RTL and testbench

//  Inverse of the bundle-vector flattening: accepts a packed 126-bit word as a stream of BEAT_W-bit

---
 rtl/bundle_vec_unpack.sv | 161 ++++++++++++++++
 tb/tb_bundle_vec_unpack.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bundle_vec_unpack.sv
// Reassembles a 126-bit bundle-vector frame from BEAT_W-bit beats and presents it as per-element fields.
// Optional feature macro: UNPACK_PARITY_EN (per-beat even parity on in_data, adds in_par / err_parity).
module bundle_vec_unpack #(
   parameter int BEAT_W = 16
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [BEAT_W-1:0] in_data,
   input  logic              in_last,
`ifdef UNPACK_PARITY_EN
   input  logic              in_par,
   output logic              err_parity,
`endif
   output logic              out_valid,
   input  logic              out_ready,
   output logic [9:0]        out_a_0,
   output logic [9:0]        out_a_1,
   output logic              out_bar_c_0_0,
   output logic              out_bar_c_0_1,
   output logic              out_bar_c_1_0,
   output logic              out_bar_c_1_1,
   output logic [19:0]       out_bar_d_0_0,
   output logic [19:0]       out_bar_d_0_1,
   output logic [19:0]       out_bar_d_1_0,
   output logic [19:0]       out_bar_d_1_1,
   output logic [10:0]       out_b_0,
   output logic [10:0]       out_b_1,
   output logic              err_frame
);
   localparam int FRAME_W = 126;
   localparam int ELEM_W  = 63;
   localparam int BEATS   = (FRAME_W + BEAT_W - 1) / BEAT_W;
   localparam int CNT_W   = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int LAST_W  = FRAME_W - (BEATS - 1) * BEAT_W;

   typedef enum logic {FILL, HOLD} state_t;

   state_t               state_reg;
   logic [CNT_W-1:0]     count_reg;
   logic [FRAME_W-1:0]   frame_reg;
   logic [FRAME_W-1:0]   frame_next;
   logic                 out_valid_reg;
   logic                 err_frame_reg;
   logic                 beat_accept;
   logic                 at_last;
   logic                 frame_end;
   logic                 frame_ok;
   logic                 frame_par_bad;

   assign in_ready    = (state_reg == FILL);
   assign beat_accept = in_valid & in_ready;
   assign at_last     = (count_reg == CNT_W'(BEATS - 1));
   assign frame_end   = in_last | at_last;
   assign frame_ok    = in_last & at_last;

`ifdef UNPACK_PARITY_EN
   logic par_bad_reg;
   logic err_parity_reg;
   // A beat is bad when in_par does not make the total ones-count even.
   assign frame_par_bad = par_bad_reg | (in_par ^ (^in_data));
   assign err_parity    = err_parity_reg;
`else
   assign frame_par_bad = 1'b0;
`endif

   // Each beat owns a fixed slice; the final beat keeps only the bits that fit in 126.
   generate
      for (genvar gi = 0; gi < BEATS; gi++) begin : g_slice
         localparam int LO = gi * BEAT_W;
         localparam int W  = (gi == BEATS - 1) ? LAST_W : BEAT_W;
         assign frame_next[LO +: W] = (beat_accept && (count_reg == CNT_W'(gi)))
                                      ? in_data[W-1:0] : frame_reg[LO +: W];
      end
   endgenerate

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_reg      <= FILL;
         count_reg      <= '0;
         frame_reg      <= '0;
         out_valid_reg  <= 1'b0;
         err_frame_reg  <= 1'b0;
`ifdef UNPACK_PARITY_EN
         par_bad_reg    <= 1'b0;
         err_parity_reg <= 1'b0;
`endif
      end else begin
         frame_reg     <= frame_next;
         err_frame_reg <= 1'b0;
`ifdef UNPACK_PARITY_EN
         err_parity_reg <= 1'b0;
`endif
         case (state_reg)
            FILL: begin
               if (beat_accept) begin
                  if (frame_end) begin
                     count_reg     <= '0;
                     err_frame_reg <= ~frame_ok;
`ifdef UNPACK_PARITY_EN
                     par_bad_reg    <= 1'b0;
                     err_parity_reg <= frame_par_bad;
`endif
                     if (frame_ok && !frame_par_bad) begin
                        state_reg     <= HOLD;
                        out_valid_reg <= 1'b1;
                     end
                  end else begin
                     count_reg <= count_reg + 1'b1;
`ifdef UNPACK_PARITY_EN
                     par_bad_reg <= frame_par_bad;
`endif
                  end
               end
            end
            HOLD: begin
               if (out_ready) begin
                  state_reg     <= FILL;
                  out_valid_reg <= 1'b0;
               end
            end
            default: state_reg <= FILL;
         endcase
      end
   end

   assign out_valid = out_valid_reg;
   assign err_frame = err_frame_reg;

   // Element layout (LSB up): b[10:0], bar0.d[30:11], bar0.c[31], bar1.d[51:32], bar1.c[52], a[62:53].
   logic [9:0]  elem_a [2];
   logic [10:0] elem_b [2];
   logic [19:0] elem_d [2][2];
   logic        elem_c [2][2];

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_elem
         localparam int BASE = gi * ELEM_W;
         assign elem_b[gi]    = frame_reg[BASE      +: 11];
         assign elem_d[gi][0] = frame_reg[BASE + 11 +: 20];
         assign elem_c[gi][0] = frame_reg[BASE + 31];
         assign elem_d[gi][1] = frame_reg[BASE + 32 +: 20];
         assign elem_c[gi][1] = frame_reg[BASE + 52];
         assign elem_a[gi]    = frame_reg[BASE + 53 +: 10];
      end
   endgenerate

   assign out_a_0       = elem_a[0];
   assign out_a_1       = elem_a[1];
   assign out_b_0       = elem_b[0];
   assign out_b_1       = elem_b[1];
   assign out_bar_c_0_0 = elem_c[0][0];
   assign out_bar_c_0_1 = elem_c[0][1];
   assign out_bar_c_1_0 = elem_c[1][0];
   assign out_bar_c_1_1 = elem_c[1][1];
   assign out_bar_d_0_0 = elem_d[0][0];
   assign out_bar_d_0_1 = elem_d[0][1];
   assign out_bar_d_1_0 = elem_d[1][0];
   assign out_bar_d_1_1 = elem_d[1][1];
endmodule

// File: tb/tb_bundle_vec_unpack.sv
// Directed bench for bundle_vec_unpack: frame-level scoreboard plus hand-computed field checks.
`timescale 1ns/1ps
module tb_bundle_vec_unpack;
   localparam int BEAT_W = 16;
   localparam int BEATS  = 8;

   logic              clock = 1'b0;
   logic              reset_n = 1'b0;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [BEAT_W-1:0] in_data = '0;
   logic              in_last = 1'b0;
`ifdef UNPACK_PARITY_EN
   logic              in_par = 1'b0;
   logic              err_parity;
`endif
   logic              out_valid;
   logic              out_ready = 1'b1;
   logic [9:0]        out_a_0, out_a_1;
   logic              out_bar_c_0_0, out_bar_c_0_1, out_bar_c_1_0, out_bar_c_1_1;
   logic [19:0]       out_bar_d_0_0, out_bar_d_0_1, out_bar_d_1_0, out_bar_d_1_1;
   logic [10:0]       out_b_0, out_b_1;
   logic              err_frame;

   bundle_vec_unpack #(.BEAT_W(BEAT_W)) dut (
      .clock(clock), .reset_n(reset_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
`ifdef UNPACK_PARITY_EN
      .in_par(in_par), .err_parity(err_parity),
`endif
      .out_valid(out_valid), .out_ready(out_ready),
      .out_a_0(out_a_0), .out_a_1(out_a_1),
      .out_bar_c_0_0(out_bar_c_0_0), .out_bar_c_0_1(out_bar_c_0_1),
      .out_bar_c_1_0(out_bar_c_1_0), .out_bar_c_1_1(out_bar_c_1_1),
      .out_bar_d_0_0(out_bar_d_0_0), .out_bar_d_0_1(out_bar_d_0_1),
      .out_bar_d_1_0(out_bar_d_1_0), .out_bar_d_1_1(out_bar_d_1_1),
      .out_b_0(out_b_0), .out_b_1(out_b_1),
      .err_frame(err_frame)
   );

   always #5 clock = ~clock;

   int n_tests = 0;
   int n_fail  = 0;

   // Frame-level model state.
   logic         exp_valid = 1'b0;
   logic         exp_err   = 1'b0;
   logic         exp_perr  = 1'b0;
   logic [125:0] exp_frame = '0;
   int           pos       = 0;
   logic         model_bad = 1'b0;
   int           frame_no  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] fld(input logic [125:0] f, input int lo, input int w);
      logic [125:0] t;
      t = f >> lo;
      return t[31:0] & ((32'd1 << w) - 32'd1);
   endfunction

   // Compare process: every falling edge, outputs against the model.
   initial begin
      forever begin
         @(negedge clock);
         chk("out_valid", 32'(out_valid), 32'(exp_valid));
         chk("in_ready", 32'(in_ready), 32'(!exp_valid));
         chk("err_frame", 32'(err_frame), 32'(exp_err));
`ifdef UNPACK_PARITY_EN
         chk("err_parity", 32'(err_parity), 32'(exp_perr));
`endif
         if (exp_valid) begin
            chk("b_0",   32'(out_b_0),       fld(exp_frame, 0, 11));
            chk("d_0_0", 32'(out_bar_d_0_0), fld(exp_frame, 11, 20));
            chk("c_0_0", 32'(out_bar_c_0_0), fld(exp_frame, 31, 1));
            chk("d_0_1", 32'(out_bar_d_0_1), fld(exp_frame, 32, 20));
            chk("c_0_1", 32'(out_bar_c_0_1), fld(exp_frame, 52, 1));
            chk("a_0",   32'(out_a_0),       fld(exp_frame, 53, 10));
            chk("b_1",   32'(out_b_1),       fld(exp_frame, 63, 11));
            chk("d_1_0", 32'(out_bar_d_1_0), fld(exp_frame, 74, 20));
            chk("c_1_0", 32'(out_bar_c_1_0), fld(exp_frame, 94, 1));
            chk("d_1_1", 32'(out_bar_d_1_1), fld(exp_frame, 95, 20));
            chk("c_1_1", 32'(out_bar_c_1_1), fld(exp_frame, 115, 1));
            chk("a_1",   32'(out_a_1),       fld(exp_frame, 116, 10));
         end
         exp_err  = 1'b0;
         exp_perr = 1'b0;
         if (exp_valid && out_ready) exp_valid = 1'b0;
      end
   end

   task automatic wait_ready();
      int g = 0;
      while (!in_ready) begin
         g++;
         if (g > 50) begin
            chk("ready_timeout", 32'(in_ready), 32'd1);
            return;
         end
         @(posedge clock); #1;
      end
   endtask

   // Sends n beats of f; in_last on beat last_idx; parity flipped on beat flip_idx.
   task automatic send_frame(input logic [125:0] f, input int n, input int last_idx, input int flip_idx);
      logic ended, good;
      for (int k = 0; k < n; k++) begin
         wait_ready();
         in_valid = 1'b1;
         in_data  = BEAT_W'(f >> (k * BEAT_W));
         in_last  = (k == last_idx);
`ifdef UNPACK_PARITY_EN
         in_par   = (^in_data) ^ (k == flip_idx);
         if (k == flip_idx) model_bad = 1'b1;
`endif
         @(posedge clock); #1;
         ended = (k == last_idx) || (pos == BEATS - 1);
         if (ended) begin
            good = (k == last_idx) && (pos == BEATS - 1);
            if (good && !model_bad) begin
               exp_valid = 1'b1;
               exp_frame = f;
            end
            exp_err   = !good;
            exp_perr  = model_bad;
            model_bad = 1'b0;
            pos       = 0;
         end else begin
            pos++;
         end
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      frame_no++;
      $display("[TB] frame %0d: %0d beats, last_idx=%0d, flip_idx=%0d, data=%h", frame_no, n, last_idx, flip_idx, f);
   endtask

   task automatic apply_reset();
      reset_n   = 1'b0;
      in_valid  = 1'b0;
      exp_valid = 1'b0;
      exp_err   = 1'b0;
      exp_perr  = 1'b0;
      pos       = 0;
      model_bad = 1'b0;
      @(negedge clock);
      chk("rst_a_0", 32'(out_a_0), 32'd0);
      chk("rst_a_1", 32'(out_a_1), 32'd0);
      chk("rst_b_0", 32'(out_b_0), 32'd0);
      chk("rst_b_1", 32'(out_b_1), 32'd0);
      chk("rst_d_1_1", 32'(out_bar_d_1_1), 32'd0);
      chk("rst_c_0_0", 32'(out_bar_c_0_0), 32'd0);
      @(posedge clock); #1;
      reset_n = 1'b1;
   endtask

   initial begin
      #1000000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [125:0] f;
      logic [127:0] tmp;

      repeat (2) @(posedge clock);
      #1;
      apply_reset();

      // 1: single bit frame.
      send_frame(126'h1, 8, 7, -1);
      @(negedge clock);
      chk("t1_out_valid", 32'(out_valid), 32'd1);
      chk("t1_in_ready", 32'(in_ready), 32'd0);
      chk("t1_b_0", 32'(out_b_0), 32'd1);
      chk("t1_a_1", 32'(out_a_1), 32'd0);
      @(posedge clock); #1;

      // 2: sparse fields with a 5-cycle consumer stall.
      out_ready = 1'b0;
      f = (126'h3FF << 116) | (126'hABCDE << 95) | (126'h1 << 31);
      send_frame(f, 8, 7, -1);
      @(negedge clock);
      chk("t2_a_1", 32'(out_a_1), 32'h3FF);
      chk("t2_d_1_1", 32'(out_bar_d_1_1), 32'hABCDE);
      chk("t2_c_0_0", 32'(out_bar_c_0_0), 32'd1);
      chk("t2_b_0", 32'(out_b_0), 32'd0);
      repeat (5) @(posedge clock);
      #1;
      chk("t2_hold_valid", 32'(out_valid), 32'd1);
      out_ready = 1'b1;

      // 3: early in_last, then a clean frame.
      tmp = 128'h0123456789ABCDEF_FEDCBA9876543210;
      send_frame(tmp[125:0], 4, 3, -1);
      @(negedge clock);
      chk("t3_err_frame", 32'(err_frame), 32'd1);
      chk("t3_no_valid", 32'(out_valid), 32'd0);
      @(posedge clock); #1;
      send_frame(tmp[125:0], 8, 7, -1);

      // 4: missing in_last on final beat, then a clean frame.
      tmp = 128'hDEADBEEF_CAFEF00D_12345678_9ABCDEF0;
      send_frame(tmp[125:0], 8, -1, -1);
      @(negedge clock);
      chk("t4_err_frame", 32'(err_frame), 32'd1);
      @(posedge clock); #1;
      send_frame(tmp[125:0], 8, 7, -1);

      // 5: reset mid-frame, then a clean frame.
      send_frame({126{1'b1}}, 5, -1, -1);
      apply_reset();
      send_frame({126{1'b1}}, 8, 7, -1);
      @(negedge clock);
      chk("t5_a_0", 32'(out_a_0), 32'h3FF);
      chk("t5_d_0_1", 32'(out_bar_d_0_1), 32'hFFFFF);
      chk("t5_b_1", 32'(out_b_1), 32'h7FF);
      @(posedge clock); #1;

`ifdef UNPACK_PARITY_EN
      // 6: parity error on beat 2, then a clean frame.
      tmp = 128'h5555_AAAA_0F0F_F0F0_1357_9BDF_2468_ACE0;
      send_frame(tmp[125:0], 8, 7, 2);
      @(negedge clock);
      chk("t6_err_parity", 32'(err_parity), 32'd1);
      chk("t6_no_valid", 32'(out_valid), 32'd0);
      @(posedge clock); #1;
      send_frame(tmp[125:0], 8, 7, -1);
`endif

      // Back-to-back frames with out_ready held high.
      tmp = 128'h0000_0000_0000_0003_8000_0000_0000_0001;
      send_frame(tmp[125:0], 8, 7, -1);
      tmp = 128'h3FFF_0000_FFFF_0000_FFFF_0000_FFFF_0000;
      send_frame(tmp[125:0], 8, 7, -1);

      repeat (4) @(posedge clock);
      #1;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
